seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
Multi-cycle shifter for the MIPS datapath covering the right-shift direction. The existing left-shift path is fixed at 2 bits and purely combinational; this block adds variable-amount shifts.
- Supports SRL, SRA and ROR, plus SLL for completeness.
- Shifts one bit per clock under a start/busy/done handshake.
- Sits beside the ALU and serves the shift instructions (shamt field or rs[4:0]) when the multi-cycle controller is in use.

Parameters:
WIDTH, 32, operand/result width in bits
SHW, 5, shift-amount width; must equal clog2(WIDTH)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
start  input  1  request pulse; sampled only in IDLE
op  input  2  00 SLL, 01 SRL, 10 ROR, 11 SRA
shamt  input  SHW  shift amount, 0..WIDTH-1
operand  input  WIDTH  value to shift
busy  output  1  high in SHIFT state
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  shifted value; held until next accepted start

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, internal cnt=0, internal data=0, internal op register=00.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - With start=1: latch operand into data, op into op_r, shamt into cnt.
  - Next state is SHIFT if shamt!=0; DONE if shamt==0 (data passes unchanged).
  - With start=0: remain in IDLE.
- SHIFT, on each edge:
  - data <= one-bit step of data per op_r; cnt <= cnt-1.
  - When cnt==1 before the edge, next state is DONE; otherwise remain in SHIFT.
- One-bit step:
  - SLL: {data[W-2:0],0}.
  - SRL: {0,data[W-1:1]}.
  - SRA: {data[W-1],data[W-1:1]}.
  - ROR: {data[0],data[W-1:1]}.
- DONE: done=1 for exactly one cycle; result <= data registered on entry, so result is valid in the same cycle done is high. Unconditional return to IDLE.
- Latency: start sampled at edge N → done high in the cycle after edge N+shamt, i.e. shamt+1 cycles (1 for shamt=0, WIDTH for shamt=WIDTH-1).
- Start handling:
  - start while busy or in DONE is ignored, not queued.
  - Back-to-back operation: start may be reasserted in the cycle after done (IDLE).
- Operand/op/shamt are only sampled at accept; later changes have no effect on the operation in flight.
- result changes only on DONE entry or reset; it remains stable through the next operation until that operation's done.
- Reset mid-operation: immediate return to IDLE with all reset values; the in-flight operation is lost and no done is produced.
- Throughput: one operation per shamt+2 cycles.

Decomposition:
- Shared package (shift_pkg):
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_ROR=2'b10, OP_SRA=2'b11.
  - State encodings S_IDLE, S_SHIFT, S_DONE.
- One natural sub-module, shift_step: combinational WIDTH-bit single-bit shifter selected by op. It is instantiated once inside the datapath register loop.
- FSM and counter live in the top module.

Test Plan:
- Reset during SHIFT: after start SRL 0x80000000 shamt=8, assert rst at cycle 3 → busy=0, done=0, result=0 immediately; no done is ever produced; a following start SLL 0x1 shamt=1 completes normally with result=0x00000002.
- Basic right shifts:
  - SRL 0xF0000000, shamt=4 → done in 5th cycle after start, result=0x0F000000, busy high for exactly 4 cycles.
  - SRA 0x80000000, shamt=31 → done after 32 cycles, result=0xFFFFFFFF.
  - SRA 0x40000000, shamt=2 → result=0x10000000.
- Zero shift: ROR 0x12345678, shamt=0 → done on the next cycle, busy never high, result=0x12345678.
- Rotate and left: ROR 0x00000001, shamt=1 → 0x80000000; SLL 0x00000001, shamt=31 → 0x80000000.
- Handshake:
  - start held high throughout SRL 0xFF, shamt=3 → exactly one done, result=0x1F.
  - operand changed to 0xDEAD mid-shift → still 0x1F.
  - Next start accepted the cycle after done.
- Back-to-back: SLL 0x3 shamt=2 then immediately SRL 0xC shamt=2 → results 0xC then 0x3; result holds 0xC until the second done.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: operation codes, FSM states and default widths.
package shift_pkg;

  localparam int unsigned SHIFT_WIDTH = 32;
  localparam int unsigned SHIFT_SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift of a WIDTH-bit word, direction and fill chosen by op.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c
);

  always_comb begin
    dout_c = din;
    case (op)
      OP_SLL:  dout_c = {din[WIDTH-2:0], 1'b0};
      OP_SRL:  dout_c = {1'b0, din[WIDTH-1:1]};
      OP_ROR:  dout_c = {din[0], din[WIDTH-1:1]};
      OP_SRA:  dout_c = {din[WIDTH-1], din[WIDTH-1:1]};
      default: dout_c = din;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle variable shifter: one bit per clock under a start/busy/done handshake.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH,
  parameter int unsigned SHW   = SHIFT_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state, state_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0] data, data_n, step_c;
  logic [1:0]       op_r, op_n;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_r),
    .din    (data),
    .dout_c (step_c)
  );

  // Next-state and datapath selection
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data;
    op_n    = op_r;
    case (state)
      S_IDLE: begin
        if (start) begin
          data_n  = operand;
          op_n    = op;
          cnt_n   = shamt;
          state_n = (shamt != SHW'(0)) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        data_n = step_c;
        cnt_n  = cnt - SHW'(1);
        if (cnt == SHW'(1)) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decode from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      data   <= '0;
      op_r   <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      data  <= data_n;
      op_r  <= op_n;
      busy  <= (state_n == S_SHIFT);
      done  <= (state_n == S_DONE);
      if (state_n == S_DONE) result <= data_n;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: driver pushes model results, monitor checks each done.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] operand;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          sh;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] last_exp = 32'h0;

  seq_shift_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input int sh);
    logic [63:0] dbl;
    dbl = {x, x} >> sh;
    case (o)
      2'b00:   return x << sh;
      2'b01:   return x >> sh;
      2'b10:   return dbl[31:0];
      default: return 32'($signed(x) >>> sh);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every sampled cycle either retires one expected operation or checks result is held
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("latency", 32'(cyc - e.acc), 32'(e.sh));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.sh));
          chk("busy_in_done", 32'(busy), 32'h0);
          last_exp = e.res;
        end
        busy_cnt = 0;
      end else begin
        chk("result_hold", result, last_exp);
        if (busy) busy_cnt++;
      end
    end
  end

  // mode 0: quiet, 1: random garbage on inputs, 2: start held high with a changed operand
  task automatic wait_done(input int mode);
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
      @(negedge clk);
      case (mode)
        1: begin
          start   = 1'($urandom);
          op      = 2'($urandom);
          shamt   = 5'($urandom);
          operand = $urandom;
        end
        2: begin start = 1'b1; operand = 32'hDEAD; end
        default: start = 1'b0;
      endcase
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done expected done within 100 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input int sh, input int mode);
    @(negedge clk);
    start = 1'b1; op = o; operand = x; shamt = 5'(sh);
    q.push_back('{res: model(o, x, sh), sh: sh, acc: cyc + 1});
    wait_done(mode);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; shamt = '0; operand = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_result", result, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-shift: in-flight operation is abandoned
    @(negedge clk);
    start = 1'b1; op = 2'b01; operand = 32'h8000_0000; shamt = 5'd8;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0; busy_cnt = 0; last_exp = 32'h0;
    repeat (12) @(negedge clk);
    issue(2'b00, 32'h1, 1, 0);

    issue(2'b01, 32'hF000_0000, 4, 0);
    issue(2'b11, 32'h8000_0000, 31, 0);
    issue(2'b11, 32'h4000_0000, 2, 0);
    issue(2'b10, 32'h1234_5678, 0, 0);
    issue(2'b10, 32'h0000_0001, 1, 0);
    issue(2'b00, 32'h0000_0001, 31, 0);

    // start held high through SHIFT and DONE while the operand changes
    issue(2'b01, 32'h0000_00FF, 3, 2);
    @(negedge clk); start = 1'b0; operand = 32'h0;
    repeat (3) @(negedge clk);

    // Back-to-back: second start lands in the IDLE cycle right after done
    issue(2'b00, 32'h3, 2, 0);
    issue(2'b01, 32'hC, 2, 0);

    for (int i = 0; i < 40; i++)
      issue(2'($urandom), $urandom, int'($urandom_range(0, 31)), (i % 2 == 0) ? 1 : 0);
    @(negedge clk); start = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
